// File: rtl/adder_accumulator.sv
// Frame accumulator for ripple-carry adder results: sums COUNT {cout,sum} samples per frame.
// Define ACC_SATURATE_EN to clamp the frame total to all-ones on overflow instead of wrapping.
module adder_accumulator #(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 8,
  parameter int COUNT     = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     sum_in,
  input  logic                 cout_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 clear,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 out_ovf,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           frame_count
);

  localparam int CNT_W = $clog2(COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t               state, state_next;
  logic [ACC_WIDTH-1:0] acc, acc_next;
  logic [CNT_W-1:0]     cnt, cnt_next, cnt_inc;
  logic                 ovf, ovf_next;
  logic                 out_valid_next, out_ovf_next;
  logic [ACC_WIDTH-1:0] out_data_next;
  logic [7:0]           frame_count_next;

  logic [ACC_WIDTH-1:0] sample;
  logic [ACC_WIDTH:0]   sum_wide;
  logic [ACC_WIDTH-1:0] acc_add;
  logic                 ovf_add;
  logic                 accept;

  // Ready depends only on registered state, never on out_ready.
  assign in_ready = !out_valid;
  assign accept   = in_valid && in_ready;
  assign sample   = ACC_WIDTH'({cout_in, sum_in});
  assign sum_wide = {1'b0, acc} + {1'b0, sample};
  assign cnt_inc  = cnt + CNT_W'(1);

  always_comb begin
    ovf_add = ovf | sum_wide[ACC_WIDTH];
`ifdef ACC_SATURATE_EN
    acc_add = ovf_add ? '1 : sum_wide[ACC_WIDTH-1:0];
`else
    acc_add = sum_wide[ACC_WIDTH-1:0];
`endif
  end

  always_comb begin
    state_next       = state;
    acc_next         = acc;
    cnt_next         = cnt;
    ovf_next         = ovf;
    out_valid_next   = out_valid;
    out_data_next    = out_data;
    out_ovf_next     = out_ovf;
    frame_count_next = frame_count;
    if (clear) begin
      state_next     = IDLE;
      acc_next       = '0;
      cnt_next       = '0;
      ovf_next       = 1'b0;
      out_valid_next = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc_next = sample;
            cnt_next = CNT_W'(1);
            ovf_next = 1'b0;
            if (COUNT == 1) begin
              state_next     = DONE;
              out_valid_next = 1'b1;
              out_data_next  = sample;
              out_ovf_next   = 1'b0;
            end else begin
              state_next = ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_next = acc_add;
            ovf_next = ovf_add;
            cnt_next = cnt_inc;
            if (cnt_inc == CNT_LAST) begin
              state_next     = DONE;
              out_valid_next = 1'b1;
              out_data_next  = acc_add;
              out_ovf_next   = ovf_add;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_next       = IDLE;
            acc_next         = '0;
            cnt_next         = '0;
            ovf_next         = 1'b0;
            out_valid_next   = 1'b0;
            frame_count_next = frame_count + 8'd1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      ovf         <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_ovf     <= 1'b0;
      frame_count <= '0;
    end else begin
      state       <= state_next;
      acc         <= acc_next;
      cnt         <= cnt_next;
      ovf         <= ovf_next;
      out_valid   <= out_valid_next;
      out_data    <= out_data_next;
      out_ovf     <= out_ovf_next;
      frame_count <= frame_count_next;
    end
  end

endmodule

// File: tb/tb_adder_accumulator.sv
// Randomized self-checking bench for adder_accumulator; a COUNT=4 and a COUNT=16 instance.
// The frame model tracks ACC_SATURATE_EN so the same bench covers both builds.
module tb_adder_accumulator;

  localparam int AW   = 8;
  localparam int MAXV = (1 << AW) - 1;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] sum_in;
  logic       cout_in, in_valid, in_ready, clear, out_ovf, out_valid, out_ready;
  logic [7:0] out_data, frame_count;

  logic [3:0] b_sum_in;
  logic       b_cout_in, b_in_valid, b_in_ready, b_clear, b_out_ovf, b_out_valid, b_out_ready;
  logic [7:0] b_out_data, b_frame_count;

  int n_cmp = 0;
  int n_err = 0;
  int mdl_fc = 0;
  int b_fc = 0;
  int n_frames = 0;

  always #5 clk = ~clk;

  adder_accumulator #(.WIDTH(4), .ACC_WIDTH(8), .COUNT(4)) dut (
    .clk(clk), .reset_n(reset_n), .sum_in(sum_in), .cout_in(cout_in),
    .in_valid(in_valid), .in_ready(in_ready), .clear(clear),
    .out_data(out_data), .out_ovf(out_ovf), .out_valid(out_valid),
    .out_ready(out_ready), .frame_count(frame_count)
  );

  adder_accumulator #(.WIDTH(4), .ACC_WIDTH(8), .COUNT(16)) dut16 (
    .clk(clk), .reset_n(reset_n), .sum_in(b_sum_in), .cout_in(b_cout_in),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .clear(b_clear),
    .out_data(b_out_data), .out_ovf(b_out_ovf), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .frame_count(b_frame_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Frame result from plain arithmetic on the whole sample list.
  task automatic model(input int vals[$], output int data, output int ovf);
    int total = 0;
    foreach (vals[i]) total += vals[i];
    ovf = (total > MAXV) ? 1 : 0;
`ifdef ACC_SATURATE_EN
    data = (total > MAXV) ? MAXV : total;
`else
    data = total % (MAXV + 1);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v);
    int guard = 0;
    sum_in   = v[3:0];
    cout_in  = v[4];
    in_valid = 1'b1;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!in_ready) check("send_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input int vals[$], input int hold, input bit gaps);
    int d, o;
    out_ready = (hold == 0);
    foreach (vals[i]) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      send(vals[i]);
      if (i < vals.size() - 1) check("mid_valid", out_valid, 0);
    end
    model(vals, d, o);
    check("lat_valid", out_valid, 1);
    check("data", out_data, d);
    check("ovf", out_ovf, o);
    if (hold > 0) begin
      in_valid = 1'b1;
      sum_in   = 4'($urandom_range(0, 15));
      repeat (hold) begin
        tick();
        check("hold_ready", in_ready, 0);
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, d);
      end
      out_ready = 1'b1;
    end
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    mdl_fc    = (mdl_fc + 1) % 256;
    n_frames++;
    check("handoff_valid", out_valid, 0);
    check("handoff_ready", in_ready, 1);
    check("frame_count", frame_count, mdl_fc);
    $display("frame %0d: data=%0d ovf=%0d frame_count=%0d", n_frames, out_data, out_ovf, frame_count);
  endtask

  task automatic frame16(input int vals[$]);
    int d, o;
    b_in_valid  = 1'b1;
    b_out_ready = 1'b1;
    foreach (vals[i]) begin
      b_sum_in  = vals[i][3:0];
      b_cout_in = vals[i][4];
      check("b_in_ready", b_in_ready, 1);
      tick();
    end
    b_in_valid = 1'b0;
    model(vals, d, o);
    check("b_valid", b_out_valid, 1);
    check("b_data", b_out_data, d);
    check("b_ovf", b_out_ovf, o);
    tick();
    b_fc = (b_fc + 1) % 256;
    check("b_handoff", b_out_valid, 0);
    check("b_frame_count", b_frame_count, b_fc);
    $display("frame16: data=%0d ovf=%0d expected %0d/%0d", b_out_data, b_out_ovf, d, o);
  endtask

  initial begin
    int q[$];
    reset_n = 1'b0; sum_in = '0; cout_in = 1'b0; in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0;
    b_sum_in = '0; b_cout_in = 1'b0; b_in_valid = 1'b0; b_clear = 1'b0; b_out_ready = 1'b0;
    repeat (3) tick();
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_ovf", out_ovf, 0);
    check("rst_fc", frame_count, 0);
    reset_n = 1'b1;
    tick();
    check("rst_ready", in_ready, 1);

    // Overflow frame: 16 x 31 = 496.
    q = {};
    repeat (16) q.push_back(31);
    frame16(q);
    repeat (3) begin
      q = {};
      repeat (16) q.push_back($urandom_range(0, 31));
      frame16(q);
    end

    // Directed frame: 2 + 4 + 6 + 17 = 29.
    q = {2, 4, 6, 17};
    run_frame(q, 0, 1'b0);

    // Consumer stalls for 10 cycles with upstream still offering data.
    q = {5, 9, 30, 1};
    run_frame(q, 10, 1'b0);

    repeat (20) begin
      q = {};
      repeat (4) q.push_back($urandom_range(0, 31));
      run_frame(q, $urandom_range(0, 3), 1'b1);
    end

    // Clear after two samples, with a competing sample offered in the clear cycle.
    out_ready = 1'b1;
    send(20); send(31);
    clear = 1'b1; in_valid = 1'b1; sum_in = 4'd7; cout_in = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    check("clr_valid", out_valid, 0);
    check("clr_ready", in_ready, 1);
    q = {1, 1, 1, 1};
    run_frame(q, 0, 1'b0);

    // Clear and out_ready together in DONE: frame discarded, not counted.
    out_ready = 1'b0;
    send(3); send(3); send(3); send(3);
    check("drop_valid_pre", out_valid, 1);
    clear = 1'b1; out_ready = 1'b1;
    tick();
    clear = 1'b0; out_ready = 1'b0;
    check("drop_valid", out_valid, 0);
    check("drop_fc", frame_count, mdl_fc);
    check("drop_ready", in_ready, 1);

    // Asynchronous reset mid-frame after three samples.
    send(11); send(12); send(13);
    #2 reset_n = 1'b0;
    #1;
    check("arst_mid_valid", out_valid, 0);
    check("arst_mid_data", out_data, 0);
    check("arst_mid_ovf", out_ovf, 0);
    check("arst_mid_fc", frame_count, 0);
    tick();
    reset_n = 1'b1;
    mdl_fc  = 0;
    tick();
    check("arst_mid_ready", in_ready, 1);
    q = {8, 8, 8, 8};
    run_frame(q, 0, 1'b0);

    // Asynchronous reset while holding a finished frame.
    out_ready = 1'b0;
    send(25); send(26); send(27); send(28);
    check("arst_done_pre", out_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_done_valid", out_valid, 0);
    check("arst_done_data", out_data, 0);
    check("arst_done_ovf", out_ovf, 0);
    check("arst_done_fc", frame_count, 0);
    tick();
    reset_n = 1'b1;
    mdl_fc  = 0;
    tick();
    check("arst_done_ready", in_ready, 1);

    // 256 back-to-back frames wrap the completed-frame counter to 0.
    repeat (256) begin
      q = {};
      repeat (4) q.push_back($urandom_range(0, 31));
      run_frame(q, 0, 1'b0);
    end
    check("fc_wrap", frame_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
